mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported unified memory between instruction fetch (IF) and data access (MEM stage).
//  One access is outstanding at a time, using a req/ack handshake on the memory side.
//  Produces the stall_if / stall_mem terms that gate PC/IF_ID and EX_MEM/MEM_WB writes alongside the load-use stall.
//  Priority policy: data wins on first contention, then strict alternation, so neither port starves.
// PARAMETERS
//  ADDR_W  32  address width, both ports and memory
//  DATA_W  32  data width, both ports and memory
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  if_req     in   1       fetch request; held high until if_ready, or until dropped on flush
//  if_addr    in   ADDR_W  fetch address; stable while if_req is high
//  if_flush   in   1       branch/jump redirect; current fetch result must be discarded
//  if_rdata   out  DATA_W  fetched instruction; valid when if_ready=1
//  if_ready   out  1       1-cycle completion pulse for the fetch port
//  dm_req     in   1       data request; held high until dm_ready
//  dm_we      in   1       1=store, 0=load
//  dm_addr    in   ADDR_W  data address; stable while dm_req is high
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data; valid when dm_ready=1
//  dm_ready   out  1       1-cycle completion pulse for the data port
//  mem_req    out  1       memory request; held high until mem_ack
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data; valid in the mem_ack cycle
//  mem_ack    in   1       1-cycle acknowledge; only legal while mem_req=1
//  stall_if   out  1       = if_req & ~if_ready & ~if_flush
//  stall_mem  out  1       = dm_req & ~dm_ready
// BEHAVIOUR
//  Reset:
//   - State = IDLE; last_dm = 0; discard = 0.
//   - mem_req, mem_we, if_ready, dm_ready = 0.
//   - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
//   - Reset mid-access drops mem_req immediately; the pending access is abandoned and no ready pulse is issued.
//  FSM states: IDLE, BUSY_IF, BUSY_DM, RESP. All outputs are registered except stall_if and stall_mem.
//  IDLE:
//   - dm_req only -> BUSY_DM.
//   - Valid if_req only -> BUSY_IF. A valid if_req is if_req & ~if_flush.
//   - Both pending -> grant IF if last_dm=1, otherwise grant DM.
//   - On grant: latch the granted port's addr, we and wdata into mem_*; set mem_req=1 next cycle.
//   - On grant: last_dm <= (grant==DM). IF accesses always use mem_we=0.
//  BUSY_x:
//   - Hold mem_req, mem_addr, mem_we and mem_wdata stable.
//   - On mem_ack: mem_req <= 0; capture mem_rdata into the port's rdata register (DM loads only); -> RESP.
//  RESP:
//   - Pulse the granted port's ready for exactly 1 cycle, then -> IDLE.
//   - Requests are not re-arbitrated in RESP, so the completing requester can drop req.
//  Latency:
//   - Request seen in IDLE at cycle 0 -> mem_req=1 at cycle 1.
//   - Ack at cycle k (k>=1) -> ready=1 at cycle k+1 -> IDLE at cycle k+2.
//  Flush:
//   - if_flush during BUSY_IF (or RESP of IF) sets discard.
//   - When discard is set, the IF completion still waits for mem_ack, because the memory access cannot be cancelled.
//   - When discard is set: if_ready is suppressed and if_rdata is not updated.
//   - discard clears on entry to IDLE.
//   - if_flush has no effect on DM accesses.
//  Stores:
//   - dm_ready pulses as for loads.
//   - dm_rdata holds its previous value.
//  mem_ack:
//   - mem_ack while mem_req=0 is ignored.
//   - mem_ack and a new request in the same cycle: the request waits until IDLE.
//  Simultaneous flush and new if_req in IDLE: no IF grant that cycle.
// TESTING
//  1. Fetch only: if_addr=0x0040_0000, mem_ack 2 cycles after mem_req, mem_rdata=0x2008_0005
//     -> if_ready=1 for 1 cycle with if_rdata=0x2008_0005; stall_if=1 until then.
//  2. Contention after reset: if_req and dm_req (load 0x1000_0010) in the same cycle
//     -> DM served first (mem_addr=0x1000_0010, mem_we=0), then IF; dm_ready precedes if_ready.
//  3. Continuous if_req and dm_req for 4 accesses -> grant order DM, IF, DM, IF.
//  4. Store: dm_we=1, dm_addr=0x1000_0020, dm_wdata=0xDEAD_BEEF
//     -> mem_we=1 with that address and data; dm_ready pulses; dm_rdata unchanged.
//  5. if_flush asserted one cycle into BUSY_IF
//     -> mem_req held until mem_ack; no if_ready pulse; if_rdata unchanged; next if_req re-arbitrated from IDLE.
//  6. rst_n low during BUSY_DM
//     -> mem_req=0 and state IDLE immediately; no dm_ready pulse after release; the first contention grants DM.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the shared memory and
// the arbiter that sits in the middle of them.
//
// Signal groups
//   if_*      fetch port      : if_req/if_addr/if_flush in, if_rdata/if_ready out
//   dm_*      data port       : dm_req/dm_we/dm_addr/dm_wdata in, dm_rdata/dm_ready out
//   mem_*     memory side     : mem_req/we/addr/wdata out, mem_rdata/mem_ack in
//   stall_*   pipeline stalls : stall_if, stall_mem out
// Modports
//   master    the arbiter (drives memory requests, ready pulses and stalls)
//   slave     the surrounding pipeline and memory model
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_if;
    logic              stall_mem;

    modport master (
        input  if_req,
        input  if_addr,
        input  if_flush,
        output if_rdata,
        output if_ready,
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ready,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack,
        output stall_if,
        output stall_mem
    );

    modport slave (
        output if_req,
        output if_addr,
        output if_flush,
        input  if_rdata,
        input  if_ready,
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ready,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack,
        input  stall_if,
        input  stall_mem
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// data access; one access outstanding, data first then strict alternation.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.master: fetch port, data port, memory
//          req/ack side, and the stall_if / stall_mem pipeline terms
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_e;

    state_e            state_q,     state_d;
    logic              last_dm_q,   last_dm_d;
    logic              discard_q,   discard_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              dm_ready_q,  dm_ready_d;

    logic              if_valid;
    logic              grant_dm;
    logic              ack;

    // A fetch being redirected this cycle is not worth starting.
    assign if_valid = bus.if_req & ~bus.if_flush;

    // Data wins unless the previous grant also went to data and a
    // fetch is waiting; this yields DM, IF, DM, IF under full load.
    assign grant_dm = bus.dm_req & ~(if_valid & last_dm_q);

    // Acks arriving with no request outstanding are dropped.
    assign ack = bus.mem_ack & mem_req_q;

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        discard_d   = discard_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (bus.dm_req | if_valid) begin
                    mem_req_d = 1'b1;
                    last_dm_d = grant_dm;
                    if (grant_dm) begin
                        state_d     = BUSY_DM;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        state_d    = BUSY_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.if_addr;
                    end
                end
            end

            BUSY_IF: begin
                if (bus.if_flush) begin
                    discard_d = 1'b1;
                end
                // The read cannot be cancelled; a flushed fetch still
                // runs to its ack but its result is thrown away.
                if (ack) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (!discard_q && !bus.if_flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end

            BUSY_DM: begin
                if (ack) begin
                    mem_req_d  = 1'b0;
                    state_d    = RESP;
                    dm_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end

            RESP: begin
                // No arbitration here so the finishing port can drop req.
                state_d   = IDLE;
                discard_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ready  = dm_ready_q;

    // Combinational so the pipeline freezes in the same cycle it asks.
    assign bus.stall_if  = bus.if_req & ~if_ready_q & ~bus.if_flush;
    assign bus.stall_mem = bus.dm_req & ~dm_ready_q;

endmodule
